// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the execute-side sources and the register-file write port.
// The master side drives the sources and the stall; the slave side is the arbiter.
interface rf_wb_arbiter_if #(
    parameter int N_SRC = 4,
    parameter int DW    = 32
);
    logic [N_SRC-1:0]    src_valid;
    logic [N_SRC*4-1:0]  src_addr;
    logic [N_SRC*DW-1:0] src_data;
    logic [N_SRC-1:0]    src_ready;
    logic                wr_stall;
    logic                wr_en;
    logic [3:0]          wr_addr;
    logic [15:0]         wr_onehot;
    logic [DW-1:0]       wr_data;
    logic [2:0]          wr_src;

    modport master (
        output src_valid, src_addr, src_data, wr_stall,
        input  src_ready, wr_en, wr_addr, wr_onehot, wr_data, wr_src
    );

    modport slave (
        input  src_valid, src_addr, src_data, wr_stall,
        output src_ready, wr_en, wr_addr, wr_onehot, wr_data, wr_src
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among N_SRC writeback
// sources, with a one-entry registered output stage and internal 4-to-16 row decode.
module rf_wb_arbiter #(
    parameter int N_SRC   = 4,
    parameter int DW      = 32,
    parameter bit DROP_R0 = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    rf_wb_arbiter_if.slave     bus
);
    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [PW-1:0]    ptr;
    logic             load;
    logic             found;
    logic [PW-1:0]    grant;
    logic [3:0]       grant_addr;
    logic [DW-1:0]    grant_data;
    logic [N_SRC-1:0] ready;

    logic             en_q;
    logic [3:0]       addr_q;
    logic [15:0]      onehot_q;
    logic [DW-1:0]    data_q;
    logic [2:0]       src_q;

    assign load = !en_q || !bus.wr_stall;

    // Scan from ptr upward, wrapping, so the source just served has lowest priority.
    always_comb begin
        found = 1'b0;
        grant = ptr;
        for (int k = 0; k < N_SRC; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N_SRC;
            if (!found && bus.src_valid[idx]) begin
                found = 1'b1;
                grant = PW'(idx);
            end
        end
    end

    always_comb begin
        grant_addr = bus.src_addr[int'(grant)*4 +: 4];
        grant_data = bus.src_data[int'(grant)*DW +: DW];
        ready      = '0;
        if (rst_n && load && found) begin
            ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            addr_q   <= '0;
            onehot_q <= '0;
            data_q   <= '0;
            src_q    <= '0;
            ptr      <= '0;
        end else if (load) begin
            if (found) begin
                addr_q <= grant_addr;
                data_q <= grant_data;
                src_q  <= 3'(grant);
                ptr    <= (int'(grant) == N_SRC - 1) ? '0 : PW'(int'(grant) + 1);
                // A dropped r0 write still completes its handshake but never reaches the file.
                if (DROP_R0 && grant_addr == 4'd0) begin
                    en_q     <= 1'b0;
                    onehot_q <= '0;
                end else begin
                    en_q     <= 1'b1;
                    onehot_q <= 16'(1) << grant_addr;
                end
            end else begin
                en_q     <= 1'b0;
                onehot_q <= '0;
            end
        end
    end

    assign bus.src_ready = ready;
    assign bus.wr_en     = en_q;
    assign bus.wr_addr   = addr_q;
    assign bus.wr_onehot = onehot_q;
    assign bus.wr_data   = data_q;
    assign bus.wr_src    = src_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Drives two arbiters (DROP_R0 off and on) with identical stimulus and checks each
// against a per-instance reference model of the arbitration rules.
module tb_rf_wb_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    int          m_ptr  [2];
    bit          m_en   [2];
    logic [3:0]  m_addr [2];
    logic [31:0] m_data [2];
    int          m_src  [2];

    rf_wb_arbiter_if #(.N_SRC(N), .DW(DW)) ifc0 ();
    rf_wb_arbiter_if #(.N_SRC(N), .DW(DW)) ifc1 ();

    rf_wb_arbiter #(.N_SRC(N), .DW(DW), .DROP_R0(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc0.slave)
    );

    rf_wb_arbiter #(.N_SRC(N), .DW(DW), .DROP_R0(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*4-1:0] a,
                                 input logic [N*DW-1:0] dt, input logic st, input logic rn);
        rst_n          = rn;
        ifc0.src_valid = v;
        ifc0.src_addr  = a;
        ifc0.src_data  = dt;
        ifc0.wr_stall  = st;
        ifc1.src_valid = v;
        ifc1.src_addr  = a;
        ifc1.src_data  = dt;
        ifc1.wr_stall  = st;
    endtask

    task automatic compare(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s dut%0d got=%0h want=%0h", tag, d, obs, exp);
        end
    endtask

    // Compares one instance's outputs against its model; write fields only matter when a write is held.
    task automatic checkOutput(input int d, input logic [N-1:0] exp_ready);
        logic [N-1:0] o_ready;
        logic         o_en;
        logic [3:0]   o_addr;
        logic [15:0]  o_onehot;
        logic [31:0]  o_data;
        logic [2:0]   o_src;
        if (d == 0) begin
            o_ready = ifc0.src_ready; o_en = ifc0.wr_en; o_addr = ifc0.wr_addr;
            o_onehot = ifc0.wr_onehot; o_data = ifc0.wr_data; o_src = ifc0.wr_src;
        end else begin
            o_ready = ifc1.src_ready; o_en = ifc1.wr_en; o_addr = ifc1.wr_addr;
            o_onehot = ifc1.wr_onehot; o_data = ifc1.wr_data; o_src = ifc1.wr_src;
        end
        compare("src_ready", d, 64'(o_ready), 64'(exp_ready));
        compare("wr_en", d, 64'(o_en), 64'(m_en[d]));
        compare("wr_onehot", d, 64'(o_onehot), m_en[d] ? (64'd1 << m_addr[d]) : 64'd0);
        if (m_en[d]) begin
            compare("wr_addr", d, 64'(o_addr), 64'(m_addr[d]));
            compare("wr_data", d, 64'(o_data), 64'(m_data[d]));
            compare("wr_src", d, 64'(o_src), 64'(m_src[d]));
        end
    endtask

    // One clock: drive at the falling edge, check mid-cycle, advance the model, wait for the rising edge.
    task automatic cycle(input logic [N-1:0] v, input logic [N*4-1:0] a,
                         input logic [N*DW-1:0] dt, input logic st, input logic rn);
        @(negedge clk);
        applyStimulus(v, a, dt, st, rn);
        #1;
        for (int d = 0; d < 2; d++) begin
            bit           load;
            bit           found;
            int           g;
            logic [N-1:0] exp_ready;
            logic [3:0]   ga;
            load  = !m_en[d] || !st;
            found = 0;
            g     = 0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr[d] + k) % N;
                if (!found && v[idx]) begin
                    found = 1;
                    g     = idx;
                end
            end
            exp_ready = (rn && load && found) ? N'(1 << g) : '0;
            checkOutput(d, exp_ready);
            if (!rn) begin
                m_en[d] = 0; m_addr[d] = '0; m_data[d] = '0; m_src[d] = 0; m_ptr[d] = 0;
            end else if (load) begin
                if (found) begin
                    ga        = a[g*4 +: 4];
                    m_ptr[d]  = (g + 1) % N;
                    m_en[d]   = !(d == 1 && ga == 4'd0);
                    m_addr[d] = ga;
                    m_data[d] = dt[g*DW +: DW];
                    m_src[d]  = g;
                end else begin
                    m_en[d] = 0;
                end
            end
        end
        @(posedge clk);
    endtask

    initial begin
        logic [N*4-1:0]  addrs;
        logic [N*DW-1:0] datas;
        total = 0;
        bad   = 0;
        addrs = {4'd3, 4'd2, 4'd1, 4'd4};
        datas = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0004};

        // Unchecked first edge settles the registers out of their power-up state.
        @(negedge clk);
        applyStimulus('1, addrs, datas, 1'b0, 1'b0);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            m_en[d] = 0; m_addr[d] = '0; m_data[d] = '0; m_src[d] = 0; m_ptr[d] = 0;
        end

        $display("[TB] reset with all sources valid");
        cycle('1, addrs, datas, 1'b0, 1'b0);
        cycle('1, addrs, datas, 1'b0, 1'b0);
        cycle('1, addrs, datas, 1'b0, 1'b1);
        cycle('0, addrs, datas, 1'b0, 1'b1);

        $display("[TB] single source");
        cycle(4'b0010, {4'd0, 4'd0, 4'd5, 4'd0}, {32'h0, 32'h0, 32'hA5A5_A5A5, 32'h0}, 1'b0, 1'b1);
        cycle('0, addrs, datas, 1'b0, 1'b1);
        cycle('0, addrs, datas, 1'b0, 1'b1);

        $display("[TB] round robin");
        addrs = {4'd9, 4'd8, 4'd7, 4'd6};
        for (int i = 0; i < 9; i++) cycle('1, addrs, datas, 1'b0, 1'b1);
        cycle('0, addrs, datas, 1'b0, 1'b1);

        $display("[TB] stall");
        addrs = {4'd12, 4'd15, 4'd11, 4'd10};
        cycle(4'b0100, addrs, datas, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle('1, addrs, datas, 1'b1, 1'b1);
        cycle('1, addrs, datas, 1'b0, 1'b1);
        cycle('0, addrs, datas, 1'b0, 1'b1);

        $display("[TB] register zero");
        cycle(4'b0001, {4'd1, 4'd1, 4'd1, 4'd0}, {32'h0, 32'h0, 32'h0, 32'hDEAD_0000}, 1'b0, 1'b1);
        cycle('0, addrs, datas, 1'b0, 1'b1);
        cycle(4'b0011, {4'd1, 4'd1, 4'd2, 4'd0}, datas, 1'b0, 1'b1);

        $display("[TB] reset during stall");
        cycle(4'b0100, addrs, datas, 1'b0, 1'b1);
        cycle('1, addrs, datas, 1'b1, 1'b1);
        cycle('1, addrs, datas, 1'b1, 1'b0);
        cycle('1, addrs, datas, 1'b1, 1'b1);
        cycle('1, addrs, datas, 1'b0, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] v;
            logic         st;
            logic         rn;
            v  = N'($urandom);
            st = ($urandom_range(0, 9) < 3);
            rn = ($urandom_range(0, 99) != 0);
            for (int s = 0; s < N; s++) begin
                addrs[s*4 +: 4]   = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
                datas[s*DW +: DW] = $urandom;
            end
            cycle(v, addrs, datas, st, rn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
